strm_rd_req: RTL
================

STRM_RD_REQ -- requirements
Module: strm_rd_req

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning 8-byte elements per cache line (offset range).
REQ-002 SHALL have parameter channels, default 2, meaning L2 write channels (BRAM slices).
REQ-003 SHALL have parameter nstrms, default 32, meaning total streams; l1_nstrms = nstrms/channels.
REQ-004 SHALL have parameter l1_ncl, default 16, meaning cache lines per stream ring.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port i_fill_v, input, 1, meaning one cache line written for stream i_fill_st.
REQ-008 SHALL have port i_fill_st, input, $clog2(nstrms), meaning global stream index of the fill.
REQ-009 SHALL have port i_dem, input, nstrms, meaning per-stream consumer demand bitmap.
REQ-010 SHALL have ports o_v output 1 and o_r input 1, meaning the read-request valid/ready handshake.
REQ-011 SHALL have ports o_ra_ch, o_ra_st, o_ra_cl, o_ra_of, outputs, widths $clog2(channels), $clog2(l1_nstrms), $clog2(l1_ncl), $clog2(WAYS), meaning the read address into the BRAM read port.
REQ-012 SHALL have ports o_free_v output 1 and o_free_st output $clog2(nstrms), meaning a line fully consumed and returned.
REQ-013 SHALL have port o_err, output, 1, meaning sticky fill-overflow error (see Configuration).

Function
REQ-014 SHALL keep per stream: avail count (0..l1_ncl, width $clog2(l1_ncl)+1), read line pointer cl, and element offset of.
REQ-015 SHALL treat stream s as eligible when i_dem[s]=1 and avail[s]>0.
REQ-016 SHALL select among eligible streams round-robin, starting search at the stream after the last granted one.
REQ-017 SHALL register the request: o_v rises the cycle after a stream becomes eligible while the output stage is empty or being accepted.
REQ-018 SHALL hold o_v and all o_ra_* stable while o_v=1 and o_r=0.
REQ-019 SHALL, on o_v&o_r, load the next grant in the same edge, giving one request per cycle sustained.
REQ-020 SHALL split the global stream index: o_ra_ch = MSBs, o_ra_st = LSBs.
REQ-021 SHALL increment the granted stream's offset at grant; at WAYS-1 it wraps to 0, cl increments modulo l1_ncl, and avail decrements.
REQ-022 SHALL pulse o_free_v one cycle with o_free_st when a line's final offset is accepted (o_v&o_r).
REQ-023 SHALL exclude a stream from grant when the already-registered request consumes its last available element.
REQ-024 SHALL increment avail[i_fill_st] on i_fill_v; fill and line-consume on the same stream in one cycle leave avail unchanged.
REQ-025 SHALL ignore a fill that would take avail beyond l1_ncl (count saturates).
REQ-026 SHALL treat deassertion of i_dem as affecting only future grants, never a registered request.

Reset
REQ-027 SHALL on reset clear all avail, cl, of, round-robin pointer to 0.
REQ-028 SHALL drive o_v=0, o_free_v=0, o_err=0, o_ra_*=0 during and after reset until new activity.
REQ-029 SHALL drop any in-flight request on reset mid-operation; no o_free_v for it.

Configuration
REQ-030 SHALL compile overflow detection only when STRM_RD_REQ_ERR_EN is defined: o_err sets on a saturating fill and holds until reset.
REQ-031 SHALL without STRM_RD_REQ_ERR_EN tie o_err to 0; saturation behaviour unchanged.

Verification
REQ-032 SHALL cover: reset, fill stream 5 once, i_dem[5]=1, o_r=1 -> 8 requests ch0 st5 cl0 of0..7 back-to-back, o_free_v with st5 on last accept, then o_v=0.
REQ-033 SHALL cover: fill streams 3 and 20, demand both -> grants alternate 3,20,3,20; stream 20 appears as ch1 st4.
REQ-034 SHALL cover: o_r=0 for 5 cycles with o_v=1 -> address held unchanged; release resumes at next offset.
REQ-035 SHALL cover: 16 lines consumed on stream 0 -> cl wraps 15->0 with 16 o_free_v pulses.
REQ-036 SHALL cover: 17 fills to stream 2 -> avail=16, o_err=1 with macro, o_err=0 without.
REQ-037 SHALL cover: fill and last-offset accept on stream 7 same cycle -> avail unchanged; reset mid-line -> o_v=0, no o_free_v.

Source files
------------

// File: rtl/strm_rd_req.sv
// Stream read-request arbiter: round-robin over demanded streams with
// available lines, issuing one element read address per cycle.
//
// Ports:
//   clk, reset      - clock, async active-high reset
//   i_fill_v/_st    - one line written into stream i_fill_st
//   i_dem           - per-stream consumer demand
//   o_v / o_r       - registered read request valid / ready
//   o_ra_ch/st/cl/of- BRAM read address (channel, local stream, line, offset)
//   o_free_v/_st    - line fully consumed, returned for stream
//   o_err           - sticky fill-overflow flag
//
// Build option: define STRM_RD_REQ_ERR_EN to enable overflow detection on
// o_err; otherwise o_err is tied low.
module strm_rd_req #(
  parameter int WAYS     = 8,
  parameter int channels = 2,
  parameter int nstrms   = 32,
  parameter int l1_ncl   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_fill_v,
  input  logic [$clog2(nstrms)-1:0]   i_fill_st,
  input  logic [nstrms-1:0]           i_dem,
  output logic                        o_v,
  input  logic                        o_r,
  output logic [$clog2(channels)-1:0] o_ra_ch,
  output logic [$clog2(nstrms/channels)-1:0] o_ra_st,
  output logic [$clog2(l1_ncl)-1:0]   o_ra_cl,
  output logic [$clog2(WAYS)-1:0]     o_ra_of,
  output logic                        o_free_v,
  output logic [$clog2(nstrms)-1:0]   o_free_st,
  output logic                        o_err
);

  localparam int L1NS = nstrms / channels;
  localparam int SW   = $clog2(nstrms);
  localparam int CW   = $clog2(channels);
  localparam int LW   = $clog2(L1NS);
  localparam int CLW  = $clog2(l1_ncl);
  localparam int OW   = $clog2(WAYS);
  localparam int AW   = CLW + 1;

  localparam logic [AW-1:0]  AV_FULL = AW'(l1_ncl);
  localparam logic [CLW-1:0] CL_LAST = CLW'(l1_ncl - 1);
  localparam logic [OW-1:0]  OF_LAST = OW'(WAYS - 1);

  logic [AW-1:0]  avail_q [nstrms];
  logic [AW-1:0]  avail_d [nstrms];
  logic [CLW-1:0] cl_q    [nstrms];
  logic [CLW-1:0] cl_d    [nstrms];
  logic [OW-1:0]  of_q    [nstrms];
  logic [OW-1:0]  of_d    [nstrms];
  logic [SW-1:0]  rr_q;

  logic           v_q;
  logic [SW-1:0]  gst_q;
  logic [CLW-1:0] gcl_q;
  logic [OW-1:0]  gof_q;
  logic           free_v_q;
  logic [SW-1:0]  free_st_q;

  logic [nstrms-1:0] elig;
  logic [nstrms-1:0] hit;
  logic [nstrms-1:0] wrap;
  logic [nstrms-1:0] fill;
  logic [nstrms-1:0] full;

  logic          found;
  logic [SW-1:0] gnt;
  logic          load;
  logic          take;
  logic          last_acc;

  // Line counts are decremented at grant of the last offset, so a
  // registered request that drains a stream already leaves avail at 0
  // and the stream drops out of the next arbitration.
  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      elig[s] = i_dem[s] && (avail_q[s] != '0);
      full[s] = (avail_q[s] == AV_FULL);
      fill[s] = i_fill_v && (i_fill_st == SW'(s));
    end
  end

  // Search starts one past the last grant; k == nstrms wraps back to
  // the last granted stream itself, so it has the lowest priority.
  always_comb begin
    found = 1'b0;
    gnt   = rr_q;
    for (int k = 1; k <= nstrms; k++) begin
      if (!found && elig[rr_q + SW'(k)]) begin
        found = 1'b1;
        gnt   = rr_q + SW'(k);
      end
    end
  end

  assign load     = !v_q || o_r;
  assign take     = load && found;
  assign last_acc = v_q && o_r && (gof_q == OF_LAST);

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      hit[s]  = take && (gnt == SW'(s));
      wrap[s] = hit[s] && (of_q[s] == OF_LAST);
    end
  end

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      avail_d[s] = avail_q[s];
      cl_d[s]    = cl_q[s];
      of_d[s]    = of_q[s];
      if (hit[s]) begin
        of_d[s] = wrap[s] ? '0 : of_q[s] + OW'(1);
      end
      if (wrap[s]) begin
        cl_d[s] = (cl_q[s] == CL_LAST) ? '0 : cl_q[s] + CLW'(1);
      end
      // Fill and line consume together cancel out.
      if (fill[s] && !wrap[s]) begin
        if (!full[s]) begin
          avail_d[s] = avail_q[s] + AW'(1);
        end
      end else if (!fill[s] && wrap[s]) begin
        avail_d[s] = avail_q[s] - AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) begin
        avail_q[s] <= '0;
        cl_q[s]    <= '0;
        of_q[s]    <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int s = 0; s < nstrms; s++) begin
        avail_q[s] <= avail_d[s];
        cl_q[s]    <= cl_d[s];
        of_q[s]    <= of_d[s];
      end
      if (take) begin
        rr_q <= gnt;
      end
    end
  end

  // Output stage: address registers only move on a new grant, so they
  // stay put through back-pressure and after the stage drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q       <= 1'b0;
      gst_q     <= '0;
      gcl_q     <= '0;
      gof_q     <= '0;
      free_v_q  <= 1'b0;
      free_st_q <= '0;
    end else begin
      if (load) begin
        v_q <= found;
      end
      if (take) begin
        gst_q <= gnt;
        gcl_q <= cl_q[gnt];
        gof_q <= of_q[gnt];
      end
      free_v_q <= last_acc;
      if (last_acc) begin
        free_st_q <= gst_q;
      end
    end
  end

`ifdef STRM_RD_REQ_ERR_EN
  logic              err_q;
  logic [nstrms-1:0] ovf;

  assign ovf = fill & ~wrap & full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|ovf) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_v       = v_q;
  assign o_ra_ch   = gst_q[SW-1 -: CW];
  assign o_ra_st   = gst_q[LW-1:0];
  assign o_ra_cl   = gcl_q;
  assign o_ra_of   = gof_q;
  assign o_free_v  = free_v_q;
  assign o_free_st = free_st_q;

endmodule
